// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register with stall hold, flush squash and write-back operand snoop.
// Optional performance counters are enabled by defining IDEX_PERF_CNT_EN.
module decode_execute_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] p0_ID,
    input  logic [15:0] p1_ID,
    input  logic [3:0]  p0Addr_ID,
    input  logic [3:0]  p1Addr_ID,
    input  logic [3:0]  regAddr_ID,
    input  logic [15:0] imm_ID,
    input  logic [15:0] pcNext_ID,
    input  logic [2:0]  aluOp_ID,
    input  logic        regWe_ID,
    input  logic        memToReg_ID,
    input  logic        memWe_ID,
    input  logic        jal_ID,
    input  logic        valid_ID,
    input  logic        forwardStall,
    input  logic        flush,
    input  logic [15:0] writeData_WB,
    input  logic [3:0]  writeAddr_WB,
    input  logic        writeEnable_WB,
    output logic [15:0] p0_EX,
    output logic [15:0] p1_EX,
    output logic [15:0] imm_EX,
    output logic [15:0] pcNext_EX,
    output logic [3:0]  p0Addr_EX,
    output logic [3:0]  p1Addr_EX,
    output logic [3:0]  regAddr_EX,
    output logic [2:0]  aluOp_EX,
    output logic        regWe_EX,
    output logic        memToReg_EX,
    output logic        memWe_EX,
    output logic        jal_EX,
    output logic        valid_EX,
    output logic        stallFront,
    output logic        bubbleEM
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [15:0] stallCount,
    output logic [15:0] flushCount
`endif
);

    typedef struct packed {
        logic [15:0] p0;
        logic [15:0] p1;
        logic [15:0] imm;
        logic [15:0] pc_next;
        logic [3:0]  p0_addr;
        logic [3:0]  p1_addr;
        logic [3:0]  reg_addr;
        logic [2:0]  alu_op;
        logic        reg_we;
        logic        mem_to_reg;
        logic        mem_we;
        logic        jal;
        logic        valid;
    } idex_t;

    idex_t stage_q, stage_d;

    // Register 0 is hard-wired zero, so a write-back to it must never be forwarded.
    function automatic logic wb_hit(input logic [3:0] addr);
        return writeEnable_WB && (writeAddr_WB != 4'd0) && (writeAddr_WB == addr);
    endfunction

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (forwardStall) begin
            if (wb_hit(stage_q.p0_addr)) stage_d.p0 = writeData_WB;
            if (wb_hit(stage_q.p1_addr)) stage_d.p1 = writeData_WB;
        end else begin
            stage_d.p0         = wb_hit(p0Addr_ID) ? writeData_WB : p0_ID;
            stage_d.p1         = wb_hit(p1Addr_ID) ? writeData_WB : p1_ID;
            stage_d.imm        = imm_ID;
            stage_d.pc_next    = pcNext_ID;
            stage_d.p0_addr    = p0Addr_ID;
            stage_d.p1_addr    = p1Addr_ID;
            stage_d.reg_addr   = regAddr_ID;
            stage_d.alu_op     = aluOp_ID;
            stage_d.reg_we     = regWe_ID    & valid_ID;
            stage_d.mem_to_reg = memToReg_ID & valid_ID;
            stage_d.mem_we     = memWe_ID    & valid_ID;
            stage_d.jal        = jal_ID      & valid_ID;
            stage_d.valid      = valid_ID;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    assign p0_EX       = stage_q.p0;
    assign p1_EX       = stage_q.p1;
    assign imm_EX      = stage_q.imm;
    assign pcNext_EX   = stage_q.pc_next;
    assign p0Addr_EX   = stage_q.p0_addr;
    assign p1Addr_EX   = stage_q.p1_addr;
    assign regAddr_EX  = stage_q.reg_addr;
    assign aluOp_EX    = stage_q.alu_op;
    assign regWe_EX    = stage_q.reg_we;
    assign memToReg_EX = stage_q.mem_to_reg;
    assign memWe_EX    = stage_q.mem_we;
    assign jal_EX      = stage_q.jal;
    assign valid_EX    = stage_q.valid;

    assign stallFront  = forwardStall & ~flush;
    assign bubbleEM    = forwardStall | flush;

`ifdef IDEX_PERF_CNT_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stallFront && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
        if (flush && stage_q.valid && (flush_count_q != 16'hFFFF))
            flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stallCount = stall_count_q;
    assign flushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed-vector bench for decode_execute_reg; counter checks run when IDEX_PERF_CNT_EN is defined.
module tb_decode_execute_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] p0_ID, p1_ID, imm_ID, pcNext_ID;
    logic [3:0]  p0Addr_ID, p1Addr_ID, regAddr_ID;
    logic [2:0]  aluOp_ID;
    logic        regWe_ID, memToReg_ID, memWe_ID, jal_ID, valid_ID;
    logic        forwardStall, flush;
    logic [15:0] writeData_WB;
    logic [3:0]  writeAddr_WB;
    logic        writeEnable_WB;
    logic [15:0] p0_EX, p1_EX, imm_EX, pcNext_EX;
    logic [3:0]  p0Addr_EX, p1Addr_EX, regAddr_EX;
    logic [2:0]  aluOp_EX;
    logic        regWe_EX, memToReg_EX, memWe_EX, jal_EX, valid_EX;
    logic        stallFront, bubbleEM;
`ifdef IDEX_PERF_CNT_EN
    logic [15:0] stallCount, flushCount;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_execute_reg dut (
        .clk(clk), .rst(rst),
        .p0_ID(p0_ID), .p1_ID(p1_ID), .p0Addr_ID(p0Addr_ID), .p1Addr_ID(p1Addr_ID),
        .regAddr_ID(regAddr_ID), .imm_ID(imm_ID), .pcNext_ID(pcNext_ID), .aluOp_ID(aluOp_ID),
        .regWe_ID(regWe_ID), .memToReg_ID(memToReg_ID), .memWe_ID(memWe_ID),
        .jal_ID(jal_ID), .valid_ID(valid_ID),
        .forwardStall(forwardStall), .flush(flush),
        .writeData_WB(writeData_WB), .writeAddr_WB(writeAddr_WB), .writeEnable_WB(writeEnable_WB),
        .p0_EX(p0_EX), .p1_EX(p1_EX), .imm_EX(imm_EX), .pcNext_EX(pcNext_EX),
        .p0Addr_EX(p0Addr_EX), .p1Addr_EX(p1Addr_EX), .regAddr_EX(regAddr_EX), .aluOp_EX(aluOp_EX),
        .regWe_EX(regWe_EX), .memToReg_EX(memToReg_EX), .memWe_EX(memWe_EX),
        .jal_EX(jal_EX), .valid_EX(valid_EX),
        .stallFront(stallFront), .bubbleEM(bubbleEM)
`ifdef IDEX_PERF_CNT_EN
        , .stallCount(stallCount), .flushCount(flushCount)
`endif
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [15:0] p0, input logic [3:0] a0,
                          input logic [15:0] p1, input logic [3:0] a1,
                          input logic [3:0] rd, input logic [2:0] op,
                          input logic [4:0] ctl);  // {valid, regWe, memToReg, memWe, jal}
        p0_ID = p0; p0Addr_ID = a0; p1_ID = p1; p1Addr_ID = a1;
        regAddr_ID = rd; aluOp_ID = op;
        {valid_ID, regWe_ID, memToReg_ID, memWe_ID, jal_ID} = ctl;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".p0"},     p0_EX, 16'h0);
        check({tag, ".p1"},     p1_EX, 16'h0);
        check({tag, ".imm"},    imm_EX, 16'h0);
        check({tag, ".pc"},     pcNext_EX, 16'h0);
        check({tag, ".addrs"},  16'({p0Addr_EX, p1Addr_EX, regAddr_EX}), 16'h0);
        check({tag, ".aluop"},  16'(aluOp_EX), 16'h0);
        check({tag, ".ctl"},    16'({valid_EX, regWe_EX, memToReg_EX, memWe_EX, jal_EX}), 16'h0);
    endtask

    initial begin
        rst = 1'b1; forwardStall = 1'b0; flush = 1'b0;
        writeEnable_WB = 1'b1; writeAddr_WB = 4'd5; writeData_WB = 16'h9999;
        imm_ID = 16'hDEAD; pcNext_ID = 16'h0F0F;
        set_id(16'hA5A5, 4'd5, 16'h5A5A, 4'd7, 4'd9, 3'd6, 5'b11111);

        // Reset with junk inputs
        tick(); tick();
        check_bubble("reset");
        check("reset.stallFront", 16'(stallFront), 16'd0);
        check("reset.bubbleEM",   16'(bubbleEM),   16'd0);

        // Plain load
        rst = 1'b0; writeEnable_WB = 1'b0;
        imm_ID = 16'h0042; pcNext_ID = 16'h0011;
        set_id(16'h1234, 4'd5, 16'h5678, 4'd6, 4'd3, 3'd5, 5'b11001);
        tick();
        check("load.p0",     p0_EX, 16'h1234);
        check("load.p1",     p1_EX, 16'h5678);
        check("load.regAddr", 16'(regAddr_EX), 16'd3);
        check("load.aluOp",  16'(aluOp_EX), 16'd5);
        check("load.ctl",    16'({valid_EX, regWe_EX, memToReg_EX, memWe_EX, jal_EX}), 16'b11001);
        check("load.imm",    imm_EX, 16'h0042);

        // Stall 1: snoop p0 (addr 5); new ID inputs must be ignored
        imm_ID = 16'h7777;
        set_id(16'hAAAA, 4'd8, 16'hBBBB, 4'd9, 4'd7, 3'd2, 5'b10110);
        forwardStall = 1'b1;
        writeEnable_WB = 1'b1; writeAddr_WB = 4'd5; writeData_WB = 16'hBEEF;
        #1;
        check("stall.stallFront", 16'(stallFront), 16'd1);
        check("stall.bubbleEM",   16'(bubbleEM),   16'd1);
        tick();
        check("stall1.p0", p0_EX, 16'hBEEF);
        check("stall1.p1", p1_EX, 16'h5678);
        check("stall1.regAddr", 16'(regAddr_EX), 16'd3);
        check("stall1.ctl", 16'({valid_EX, regWe_EX, memToReg_EX, memWe_EX, jal_EX}), 16'b11001);
        check("stall1.imm", imm_EX, 16'h0042);

        // Stall 2: snoop p1 (addr 6)
        writeAddr_WB = 4'd6; writeData_WB = 16'hCAFE;
        tick();
        check("stall2.p0", p0_EX, 16'hBEEF);
        check("stall2.p1", p1_EX, 16'hCAFE);

        // Stall 3: write-back to an unrelated register
        writeAddr_WB = 4'd12; writeData_WB = 16'h0BAD;
        tick();
        check("stall3.p0", p0_EX, 16'hBEEF);
        check("stall3.p1", p1_EX, 16'hCAFE);
`ifdef IDEX_PERF_CNT_EN
        check("perf.stallCount3", stallCount, 16'd3);
`endif

        // Flush together with stall: flush wins
        flush = 1'b1; writeEnable_WB = 1'b0;
        #1;
        check("flush.stallFront", 16'(stallFront), 16'd0);
        check("flush.bubbleEM",   16'(bubbleEM),   16'd1);
        tick();
        check_bubble("flush");
`ifdef IDEX_PERF_CNT_EN
        check("perf.flushCount1", flushCount, 16'd1);
        check("perf.stallCount_afterflush", stallCount, 16'd3);
`endif

        // Load with write-back snoop on the ID operands
        flush = 1'b0; forwardStall = 1'b0;
        writeEnable_WB = 1'b1; writeAddr_WB = 4'd9; writeData_WB = 16'h7777;
        set_id(16'h1111, 4'd9, 16'h2222, 4'd2, 4'd1, 3'd1, 5'b10000);
        tick();
        check("ldsnoop.p0", p0_EX, 16'h7777);
        check("ldsnoop.p1", p1_EX, 16'h2222);

        // Register 0 never snoops; invalid instruction drops its control bits
        writeAddr_WB = 4'd0; writeData_WB = 16'hFFFF;
        set_id(16'h0123, 4'd0, 16'h0456, 4'd0, 4'd4, 3'd3, 5'b01111);
        tick();
        check("r0.p0", p0_EX, 16'h0123);
        check("r0.p1", p1_EX, 16'h0456);
        check("inv.ctl", 16'({valid_EX, regWe_EX, memToReg_EX, memWe_EX, jal_EX}), 16'b00000);
        check("inv.regAddr", 16'(regAddr_EX), 16'd4);

        // Flushing an already-invalid instruction is not counted
        writeEnable_WB = 1'b0; flush = 1'b1;
        tick();
        check("flush_inv.valid", 16'(valid_EX), 16'd0);
`ifdef IDEX_PERF_CNT_EN
        check("perf.flushCount_inv", flushCount, 16'd1);
`endif

        // Reset in the middle of a stall
        flush = 1'b0;
        set_id(16'h3333, 4'd3, 16'h4444, 4'd4, 4'd5, 3'd4, 5'b11000);
        tick();
        check("pre_rst.valid", 16'(valid_EX), 16'd1);
        forwardStall = 1'b1; rst = 1'b1;
        tick();
        check_bubble("rst_stall");
`ifdef IDEX_PERF_CNT_EN
        check("perf.stallCount_rst", stallCount, 16'd0);
        check("perf.flushCount_rst", flushCount, 16'd0);
`endif
        forwardStall = 1'b0;
        #1;
        check("rst_stall.stallFront", 16'(stallFront), 16'd0);
        check("rst_stall.bubbleEM",   16'(bubbleEM),   16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
